sram_march_bist: RTL

- March C- built-in self-test controller for the single-RW-port `sram` macro (port 0).
- Sequences writes and reads over every address, compares read data against the expected background, and reports pass/fail plus first-failure diagnostics.
- Sits between system logic and `sram` port 0. When idle it passes system traffic through unchanged; while testing it owns the port.

---
 rtl/sram_bist_pkg.sv | 60 ++++++
 rtl/sram_march_bist_if.sv | 18 +
 rtl/sram_bist_addr_seq.sv | 34 +++
 rtl/sram_march_bist.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/sram_bist_pkg.sv
// Shared types and per-element constants for the March C- BIST controller.
package sram_bist_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_M0    = 4'd1,
      ST_M1    = 4'd2,
      ST_M2    = 4'd3,
      ST_M3    = 4'd4,
      ST_M4    = 4'd5,
      ST_M5    = 4'd6,
      ST_DRAIN = 4'd7,
      ST_DONE  = 4'd8
   } bist_state_e;

   // Backgrounds are single bits replicated across the word by the user.
   localparam logic BG0 = 1'b0;
   localparam logic BG1 = 1'b1;

   typedef struct packed {
      logic dir_down;
      logic rd_bg;
      logic wr_bg;
      logic has_read;
      logic has_write;
   } elem_info_t;

   // Per-element operation table; non-march states report no operations.
   function automatic elem_info_t elem_info(input bist_state_e s);
      elem_info_t e;
      e = '0;
      case (s)
         ST_M0:   e = '{dir_down: 1'b0, rd_bg: BG0, wr_bg: BG0, has_read: 1'b0, has_write: 1'b1};
         ST_M1:   e = '{dir_down: 1'b0, rd_bg: BG0, wr_bg: BG1, has_read: 1'b1, has_write: 1'b1};
         ST_M2:   e = '{dir_down: 1'b0, rd_bg: BG1, wr_bg: BG0, has_read: 1'b1, has_write: 1'b1};
         ST_M3:   e = '{dir_down: 1'b1, rd_bg: BG0, wr_bg: BG1, has_read: 1'b1, has_write: 1'b1};
         ST_M4:   e = '{dir_down: 1'b1, rd_bg: BG1, wr_bg: BG0, has_read: 1'b1, has_write: 1'b1};
         ST_M5:   e = '{dir_down: 1'b0, rd_bg: BG0, wr_bg: BG0, has_read: 1'b1, has_write: 1'b0};
         default: e = '0;
      endcase
      return e;
   endfunction

   // Element that follows a given state once its last address is done.
   function automatic bist_state_e next_elem(input bist_state_e s);
      bist_state_e n;
      case (s)
         ST_IDLE: n = ST_M0;
         ST_M0:   n = ST_M1;
         ST_M1:   n = ST_M2;
         ST_M2:   n = ST_M3;
         ST_M3:   n = ST_M4;
         ST_M4:   n = ST_M5;
         ST_M5:   n = ST_DRAIN;
         default: n = ST_IDLE;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/sram_march_bist_if.sv
// SRAM port-0 bundle. The master drives commands and receives read data.
interface sram_march_bist_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_WMASKS = 4
) ();
   // Commands are qualified by csb0 (active low); dout0 is valid the cycle
   // after a read (csb0=0, web0=1) and holds until the next read.
   logic                  csb0;
   logic                  web0;
   logic [NUM_WMASKS-1:0] wmask0;
   logic [ADDR_WIDTH-1:0] addr0;
   logic [DATA_WIDTH-1:0] din0;
   logic [DATA_WIDTH-1:0] dout0;

   modport master (output csb0, web0, wmask0, addr0, din0, input dout0);
   modport slave  (input csb0, web0, wmask0, addr0, din0, output dout0);
endinterface

// File: rtl/sram_bist_addr_seq.sv
// Up/down address counter with load, step and terminal-address flag.
module sram_bist_addr_seq #(
   parameter int ADDR_WIDTH = 5,
   parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_load,
   input  logic                  i_load_down,
   input  logic                  i_step,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  o_last
);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_down;

   // Load picks the start address for the direction; step never passes the end.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr <= '0;
         r_down <= 1'b0;
      end else if (i_load) begin
         r_down <= i_load_down;
         r_addr <= i_load_down ? LAST_ADDR : '0;
      end else if (i_step) begin
         r_addr <= r_down ? (r_addr - ADDR_WIDTH'(1)) : (r_addr + ADDR_WIDTH'(1));
      end
   end

   assign o_addr = r_addr;
   assign o_last = r_down ? (r_addr == '0) : (r_addr == LAST_ADDR);
endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller for SRAM port 0 with system passthrough when idle.
module sram_march_bist
   import sram_bist_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_WMASKS = 4,
   parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [CNT_WIDTH-1:0]  fail_count,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [DATA_WIDTH-1:0] fail_expected,
   output logic [DATA_WIDTH-1:0] fail_actual,
   output bist_state_e           o_dbg_state,
   sram_march_bist_if.slave      sys,
   sram_march_bist_if.master     mem
);
   bist_state_e           r_state;
   logic                  r_phase;      // 0 = read slot, 1 = write slot
   logic                  r_busy;
   logic                  r_done;
   logic                  r_pass;
   logic [CNT_WIDTH-1:0]  r_fail_count;
   logic [ADDR_WIDTH-1:0] r_fail_addr;
   logic [DATA_WIDTH-1:0] r_fail_exp;
   logic [DATA_WIDTH-1:0] r_fail_act;
   logic                  r_cmp_valid;
   logic [ADDR_WIDTH-1:0] r_cmp_addr;
   logic [DATA_WIDTH-1:0] r_cmp_exp;

   logic                  w_active;
   logic                  w_has_rd;
   logic                  w_has_wr;
   logic                  w_two_op;
   logic                  w_is_rd;
   logic                  w_is_wr;
   logic                  w_elem_end;
   logic                  w_load;
   logic                  w_step;
   logic                  w_load_down;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic                  w_last;
   logic                  w_mismatch;

   assign w_active    = r_state inside {ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5};
   assign w_has_rd    = elem_info(r_state).has_read;
   assign w_has_wr    = elem_info(r_state).has_write;
   assign w_two_op    = w_has_rd && w_has_wr;
   assign w_is_rd     = w_active && w_has_rd && (!w_has_wr || !r_phase);
   assign w_is_wr     = w_active && w_has_wr && (!w_has_rd || r_phase);
   // Two-op elements advance after the write slot, single-op ones every cycle.
   assign w_elem_end  = w_active && w_last && (!w_two_op || r_phase);
   assign w_step      = w_active && !w_elem_end && (!w_two_op || r_phase);
   assign w_load      = ((r_state == ST_IDLE) && start) || w_elem_end;
   assign w_load_down = elem_info(next_elem(r_state)).dir_down;
   assign w_mismatch  = r_cmp_valid && (mem.dout0 != r_cmp_exp);

   sram_bist_addr_seq #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RAM_DEPTH  (RAM_DEPTH)
   ) u_addr_seq (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_load),
      .i_load_down (w_load_down),
      .i_step      (w_step),
      .o_addr      (w_addr),
      .o_last      (w_last)
   );

   // Control FSM plus the compare pipeline and first-failure capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_phase      <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_fail_count <= '0;
         r_fail_addr  <= '0;
         r_fail_exp   <= '0;
         r_fail_act   <= '0;
         r_cmp_valid  <= 1'b0;
         r_cmp_addr   <= '0;
         r_cmp_exp    <= '0;
      end else begin
         r_done      <= 1'b0;
         r_cmp_valid <= w_is_rd;
         r_cmp_addr  <= w_addr;
         r_cmp_exp   <= {DATA_WIDTH{elem_info(r_state).rd_bg}};
         if (w_mismatch) begin
            if (r_fail_count != '1) r_fail_count <= r_fail_count + CNT_WIDTH'(1);
            if (r_fail_count == '0) begin
               r_fail_addr <= r_cmp_addr;
               r_fail_exp  <= r_cmp_exp;
               r_fail_act  <= mem.dout0;
            end
         end
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state      <= ST_M0;
                  r_phase      <= 1'b0;
                  r_busy       <= 1'b1;
                  r_pass       <= 1'b0;
                  r_fail_count <= '0;
                  r_fail_addr  <= '0;
                  r_fail_exp   <= '0;
                  r_fail_act   <= '0;
               end
            end
            ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5: begin
               if (w_two_op) r_phase <= ~r_phase;
               if (w_elem_end) begin
                  r_state <= next_elem(r_state);
                  r_phase <= 1'b0;
               end
            end
            ST_DRAIN: begin
               r_state <= ST_DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_pass  <= (r_fail_count == '0) && !w_mismatch;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Port mux: system traffic passes through unless the test owns the SRAM.
   always_comb begin
      mem.csb0   = sys.csb0;
      mem.web0   = sys.web0;
      mem.wmask0 = sys.wmask0;
      mem.addr0  = sys.addr0;
      mem.din0   = sys.din0;
      if (r_busy) begin
         mem.csb0   = !(w_is_rd || w_is_wr);
         mem.web0   = !w_is_wr;
         mem.wmask0 = '1;
         mem.addr0  = w_addr;
         mem.din0   = {DATA_WIDTH{elem_info(r_state).wr_bg}};
      end
   end

   assign sys.dout0     = mem.dout0;
   assign busy          = r_busy;
   assign done          = r_done;
   assign pass          = r_pass;
   assign fail_count    = r_fail_count;
   assign fail_addr     = r_fail_addr;
   assign fail_expected = r_fail_exp;
   assign fail_actual   = r_fail_act;
   assign o_dbg_state   = r_state;
endmodule
